// File: rtl/alu_reservation_station_pkg.sv
// Shared core package for the ALU reservation station.
// Provides the default widths and depth, the per-entry storage struct, and
// the dispatch-time operand builder that applies the CDB bypass.
package alu_reservation_station_pkg;

    localparam int unsigned RS_WIDTH   = 31;  // data MSB index
    localparam int unsigned RS_A_WIDTH = 3;   // ALU control MSB index
    localparam int unsigned RS_ROB     = 2;   // ROB tag MSB index
    localparam int unsigned RS_ENTRIES = 4;   // station depth

    typedef struct packed {
        logic [RS_WIDTH:0] value;
        logic              ready;
        logic [RS_ROB:0]   tag;
    } rs_operand_t;

    typedef struct packed {
        logic                valid;
        logic [RS_A_WIDTH:0] control;
        logic [RS_ROB:0]     rob;
        rs_operand_t         op1;
        rs_operand_t         op2;
    } rs_entry_t;

    // Operand as it is written into a freshly allocated entry. A not-ready
    // operand whose producer is broadcasting this very cycle is stored ready.
    function automatic rs_operand_t dispatch_operand(
        input logic [RS_WIDTH:0] value,
        input logic              ready,
        input logic [RS_ROB:0]   tag,
        input logic              cdb_valid,
        input logic [RS_ROB:0]   cdb_rob,
        input logic [RS_WIDTH:0] cdb_result
    );
        rs_operand_t op;
        op.value = value;
        op.ready = ready;
        op.tag   = tag;
        if (!ready && cdb_valid && (tag == cdb_rob)) begin
            op.value = cdb_result;
            op.ready = 1'b1;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_reservation_station_age_select.sv
// rs_age_select: age matrix plus oldest-issuable one-hot picker.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   alloc      : one-hot entry being allocated this cycle (or zero)
//   ready      : entries currently issuable
//   grant      : one-hot oldest issuable entry (zero when none)
module rs_age_select
    import alu_reservation_station_pkg::*;
#(
    parameter int unsigned ENTRIES = RS_ENTRIES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENTRIES-1:0] alloc,
    input  logic [ENTRIES-1:0] ready,
    output logic [ENTRIES-1:0] grant
);

    // older[i][j] set means entry i was allocated before entry j.
    logic [ENTRIES-1:0] older [ENTRIES];

    // A new entry is younger than everything: clear its row, set its column.
    // Stale bits for free entries are harmless; they are rewritten on allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                for (int unsigned j = 0; j < ENTRIES; j++) begin
                    if (alloc[i]) begin
                        older[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Entry i wins when no other ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            logic [ENTRIES-1:0] self;
            self    = '0;
            self[i] = 1'b1;
            grant[i] = ready[i] && !(|(ready & ~older[i] & ~self));
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// available (directly or via the common data bus) and issues the oldest ready
// op to the ALU through registered outputs, one op per cycle.
// Ports:
//   clk, globalReset        : clock, asynchronous active-low reset
//   clear                   : synchronous flush of all entries
//   dispatchValid, disp*    : new op offered with operand values/ready/tags
//   cdbValid/cdbRob/cdbResult : result broadcast
//   aluAvailable            : ALU accepts an op this cycle
//   rsFull                  : all entries occupied (combinational)
//   issueValid, src1, src2, ALUControl, ALURob : registered issue to ALU
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int unsigned WIDTH   = RS_WIDTH,
    parameter int unsigned A_WIDTH = RS_A_WIDTH,
    parameter int unsigned ROB     = RS_ROB,
    parameter int unsigned ENTRIES = RS_ENTRIES
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             clear,
    input  logic             dispatchValid,
    input  logic [A_WIDTH:0] dispALUControl,
    input  logic [ROB:0]     dispRob,
    input  logic [WIDTH:0]   dispSrc1,
    input  logic [WIDTH:0]   dispSrc2,
    input  logic             dispRdy1,
    input  logic             dispRdy2,
    input  logic [ROB:0]     dispTag1,
    input  logic [ROB:0]     dispTag2,
    input  logic             cdbValid,
    input  logic [ROB:0]     cdbRob,
    input  logic [WIDTH:0]   cdbResult,
    input  logic             aluAvailable,
    output logic             rsFull,
    output logic             issueValid,
    output logic [WIDTH:0]   src1,
    output logic [WIDTH:0]   src2,
    output logic [A_WIDTH:0] ALUControl,
    output logic [ROB:0]     ALURob
);

    rs_entry_t          entries [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] issuable;
    logic [ENTRIES-1:0] alloc;
    logic [ENTRIES-1:0] oldest;
    logic [ENTRIES-1:0] issue_sel;
    logic               do_alloc;
    logic               do_issue;
    rs_entry_t          new_entry;
    logic [WIDTH:0]     sel_src1;
    logic [WIDTH:0]     sel_src2;
    logic [A_WIDTH:0]   sel_control;
    logic [ROB:0]       sel_rob;

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid[i]    = entries[i].valid;
            issuable[i] = entries[i].valid && entries[i].op1.ready && entries[i].op2.ready;
        end
    end

    assign rsFull   = &valid;
    assign do_alloc = dispatchValid && !rsFull && !clear;
    assign do_issue = aluAvailable && (|issuable) && !clear;

    // Lowest-index free entry, from current-cycle valid bits only, so a slot
    // vacated by this cycle's issue is not reused until the next cycle.
    always_comb begin
        logic found;
        alloc = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!do_alloc) begin
            alloc = '0;
        end
    end

    rs_age_select #(
        .ENTRIES (ENTRIES)
    ) u_age_select (
        .clk   (clk),
        .rst_n (globalReset),
        .alloc (alloc),
        .ready (issuable),
        .grant (oldest)
    );

    assign issue_sel = do_issue ? oldest : '0;

    always_comb begin
        new_entry.valid   = 1'b1;
        new_entry.control = dispALUControl;
        new_entry.rob     = dispRob;
        new_entry.op1     = dispatch_operand(dispSrc1, dispRdy1, dispTag1,
                                             cdbValid, cdbRob, cdbResult);
        new_entry.op2     = dispatch_operand(dispSrc2, dispRdy2, dispTag2,
                                             cdbValid, cdbRob, cdbResult);
    end

    always_comb begin
        sel_src1    = '0;
        sel_src2    = '0;
        sel_control = '0;
        sel_rob     = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (oldest[i]) begin
                sel_src1    = entries[i].op1.value;
                sel_src2    = entries[i].op2.value;
                sel_control = entries[i].control;
                sel_rob     = entries[i].rob;
            end
        end
    end

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
            issueValid <= 1'b0;
            src1       <= '0;
            src2       <= '0;
            ALUControl <= '0;
            ALURob     <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
            issueValid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (alloc[i]) begin
                    entries[i] <= new_entry;
                end else begin
                    if (issue_sel[i]) begin
                        entries[i].valid <= 1'b0;
                    end
                    if (entries[i].valid && cdbValid) begin
                        if (!entries[i].op1.ready && entries[i].op1.tag == cdbRob) begin
                            entries[i].op1.value <= cdbResult;
                            entries[i].op1.ready <= 1'b1;
                        end
                        if (!entries[i].op2.ready && entries[i].op2.tag == cdbRob) begin
                            entries[i].op2.value <= cdbResult;
                            entries[i].op2.ready <= 1'b1;
                        end
                    end
                end
            end
            issueValid <= do_issue;
            if (do_issue) begin
                src1       <= sel_src1;
                src2       <= sel_src2;
                ALUControl <= sel_control;
                ALURob     <= sel_rob;
            end
        end
    end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter WIDTH, default 31: data MSB index (32-bit operands).
REQ-002 SHALL have parameter A_WIDTH, default 3: ALU control MSB index.
REQ-003 SHALL have parameter ROB, default 2: ROB tag MSB index (8 tags).
REQ-004 SHALL have parameter ENTRIES, default 4: station depth.
REQ-005 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have globalReset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have clear  input  1  synchronous pipeline flush (mispredict).
REQ-008 SHALL have dispatchValid  input  1  new ALU op offered.
REQ-009 SHALL have dispALUControl  input  A_WIDTH+1  op control.
REQ-010 SHALL have dispRob  input  ROB+1  destination ROB tag.
REQ-011 SHALL have dispSrc1, dispSrc2  input  WIDTH+1 each  operand values when ready.
REQ-012 SHALL have dispRdy1, dispRdy2  input  1 each  operand value already valid.
REQ-013 SHALL have dispTag1, dispTag2  input  ROB+1 each  producer tag when not ready.
REQ-014 SHALL have cdbValid  input  1; cdbRob  input  ROB+1; cdbResult  input  WIDTH+1: common data bus broadcast.
REQ-015 SHALL have aluAvailable  input  1  ALU can accept an op this cycle.
REQ-016 SHALL have rsFull  output  1  no free entry.
REQ-017 SHALL have issueValid  output  1; src1, src2  output  WIDTH+1; ALUControl  output  A_WIDTH+1; ALURob  output  ROB+1: registered issue to ALU.

Function
REQ-018 SHALL hold per entry: valid, control, rob tag, two operands each with value, ready bit, tag.
REQ-019 SHALL assert rsFull combinationally when all ENTRIES valid bits are set, from current-cycle state only.
REQ-020 SHALL allocate, on dispatchValid && !rsFull && !clear, the lowest-index free entry, written at the next edge.
REQ-021 SHALL ignore dispatchValid while rsFull (no overwrite, no error); an entry freed by issue that same cycle is not reusable until the next cycle.
REQ-022 SHALL, when cdbValid, compare cdbRob against every valid not-ready operand tag; on match capture cdbResult and set ready at the next edge.
REQ-023 SHALL bypass the CDB on dispatch: a not-ready dispatched operand whose tag equals cdbRob with cdbValid set is stored ready with cdbResult.
REQ-024 SHALL treat an entry as issuable only when both ready bits are set in registered state (CDB capture to issue minimum 1 cycle).
REQ-025 SHALL track age with an ENTRIES x ENTRIES age matrix updated on allocation; among issuable entries select the oldest.
REQ-026 SHALL, when aluAvailable and an issuable entry exists, load the output registers with that entry, clear its valid, and set issueValid at the next edge.
REQ-027 SHALL drive issueValid low at the next edge when aluAvailable is low or nothing is issuable; output data then holds its last value.
REQ-028 SHALL issue at most one op per cycle; throughput one per cycle under continuous aluAvailable.
REQ-029 SHALL, on clear, invalidate all entries and drive issueValid low at the next edge; clear overrides dispatch, capture and issue in that cycle.
REQ-030 SHALL ignore CDB broadcasts for free entries and ready operands.

Reset
REQ-031 SHALL, while globalReset is low, asynchronously clear all valid, ready and age state, issueValid, src1, src2, ALUControl, ALURob to zero; rsFull therefore reads 0.
REQ-032 SHALL discard any in-flight dispatch or issue when reset asserts mid-cycle; first dispatch accepted on the first edge after release.

Structure
REQ-033 SHALL take WIDTH, A_WIDTH, ROB, ENTRIES defaults and the entry struct typedef from the shared core package.
REQ-034 SHALL contain one sub-module rs_age_select: age matrix plus oldest-issuable one-hot picker.

Verification
REQ-035 SHALL verify: dispatch ready op src1=5 src2=7 rob=3, aluAvailable=1 -> next-next edge issueValid=1, src1=5, src2=7, ALURob=3.
REQ-036 SHALL verify: dispatch rob=1 with tag1=4 not ready; cycle later cdbValid rob=4 result=0x10 -> issue one cycle after capture with src1=0x10.
REQ-037 SHALL verify: dispatch with tag2=6 same cycle as cdbValid rob=6 result=9 -> entry stored ready, issues with src2=9.
REQ-038 SHALL verify: fill 4 entries with aluAvailable=0 -> rsFull=1, fifth dispatch dropped; raise aluAvailable -> issue order matches dispatch order.
REQ-039 SHALL verify: 3 valid entries, clear with simultaneous dispatch -> all entries empty, issueValid=0, rsFull=0 next cycle.
REQ-040 SHALL verify: assert globalReset low mid-issue -> issueValid and outputs 0 immediately, no issue after release until new dispatch.
